// File: rtl/snake_cmd_receiver_pkg.sv
// Shared types and field positions for the snake command receiver.
// Covers the command word, the ack/status word and the receiver FSM.
package snake_cmd_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_DIR   = 2'b01,
        OP_RUN   = 2'b10,
        OP_SPEED = 2'b11
    } opcode_e;

    localparam int TGL_BIT = 6;
    localparam int OP_MSB  = 5;
    localparam int OP_LSB  = 4;
    localparam int ARG_MSB = 3;
    localparam int ARG_LSB = 0;

    localparam int ACK_TGL_BIT = 6;
    localparam int ACK_OP_MSB  = 5;
    localparam int ACK_OP_LSB  = 4;
    localparam int ACK_ERR_BIT = 3;
    localparam int ACK_CNT_MSB = 2;
    localparam int ACK_CNT_LSB = 0;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_PEND = 2'd2
    } state_e;

endpackage

// File: rtl/snake_cmd_receiver_if.sv
// Command/status conduit plus the game-engine command stream.
// The receiver is the slave side; software and the game engine form the master side.
interface snake_cmd_receiver_if;
    logic [6:0] cmd_word;
    logic [6:0] ack_word;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_op;
    logic [3:0] out_arg;

    modport slave (
        input  cmd_word, out_ready,
        output ack_word, out_valid, out_op, out_arg
    );

    modport master (
        output cmd_word, out_ready,
        input  ack_word, out_valid, out_op, out_arg
    );
endinterface

// File: rtl/snake_cmd_receiver_fifo.sv
// First-word-fall-through synchronous FIFO holding decoded {op, arg} commands.
// A push is refused when full, judged on the count before any simultaneous pop.
module snake_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3,
    parameter int W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head reads as zero while empty so the stream fields are clean out of reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/snake_cmd_receiver.sv
// Detects toggled command words from software, queues non-NOP commands for the
// game engine and reports ack toggle, last opcode, protocol error and queue count.
module snake_cmd_receiver
    import snake_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    snake_cmd_receiver_if.slave  bus
);
    logic [6:0]       cmd_q;
    logic [6:0]       hold_q;
    state_e           state_q;
    logic             seen_tgl_q;
    logic             ack_tgl_q;
    opcode_e          ack_op_q;
    logic             err_q;

    opcode_e          cmd_op;
    logic             new_cmd;
    logic             push;
    logic [5:0]       push_data;
    logic [5:0]       head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // Sampled through reset too, so ARM arms against the word actually present.
    always_ff @(posedge clk) begin
        cmd_q <= bus.cmd_word;
    end

    assign cmd_op  = opcode_e'(cmd_q[OP_MSB:OP_LSB]);
    assign new_cmd = (cmd_q[TGL_BIT] != seen_tgl_q);

    always_comb begin
        push      = 1'b0;
        push_data = cmd_q[OP_MSB:ARG_LSB];
        case (state_q)
            ST_IDLE: push = new_cmd && (cmd_op != OP_NOP) && !fifo_full;
            ST_PEND: begin
                push_data = hold_q[OP_MSB:ARG_LSB];
                push      = !fifo_full;
            end
            default: push = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARM;
            seen_tgl_q <= 1'b0;
            ack_tgl_q  <= 1'b0;
            ack_op_q   <= OP_NOP;
            err_q      <= 1'b0;
            hold_q     <= '0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    seen_tgl_q <= cmd_q[TGL_BIT];
                    state_q    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (new_cmd) begin
                        if (cmd_op == OP_NOP) begin
                            seen_tgl_q <= cmd_q[TGL_BIT];
                            ack_tgl_q  <= cmd_q[TGL_BIT];
                            ack_op_q   <= OP_NOP;
                            if (cmd_q[ARG_LSB]) begin
                                err_q <= 1'b0;
                            end
                        end else if (!fifo_full) begin
                            seen_tgl_q <= cmd_q[TGL_BIT];
                            ack_tgl_q  <= cmd_q[TGL_BIT];
                            ack_op_q   <= cmd_op;
                        end else begin
                            hold_q  <= cmd_q;
                            state_q <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    // Toggle back at the acked value means software rewrote before the ack.
                    if (cmd_q[TGL_BIT] == seen_tgl_q) begin
                        err_q <= 1'b1;
                    end
                    if (!fifo_full) begin
                        seen_tgl_q <= hold_q[TGL_BIT];
                        ack_tgl_q  <= hold_q[TGL_BIT];
                        ack_op_q   <= opcode_e'(hold_q[OP_MSB:OP_LSB]);
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_ARM;
            endcase
        end
    end

    snake_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W),
        .W     (6)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (bus.out_valid && bus.out_ready),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_op    = head[5:4];
    assign bus.out_arg   = head[3:0];

    always_comb begin
        bus.ack_word                          = '0;
        bus.ack_word[ACK_TGL_BIT]             = ack_tgl_q;
        bus.ack_word[ACK_OP_MSB:ACK_OP_LSB]   = ack_op_q;
        bus.ack_word[ACK_ERR_BIT]             = err_q;
        bus.ack_word[ACK_CNT_MSB:ACK_CNT_LSB] = 3'(fifo_count);
    end
endmodule

// File: tb/tb_snake_cmd_receiver.sv
// Directed bench for the snake command receiver with a queue scoreboard on the output stream.
module tb_snake_cmd_receiver;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [5:0] sb[$];

    snake_cmd_receiver_if bus();

    snake_cmd_receiver #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Compares the head against the scoreboard if the coming edge pops, then advances one cycle.
    task automatic tick();
        logic [5:0] exp;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("pop_underflow", 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                chk("pop_head", {26'd0, bus.out_op, bus.out_arg}, {26'd0, exp});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sends a command expected to be queued and acked two edges later.
    task automatic send_acked(input logic [6:0] w, input logic [6:0] exp_ack);
        bus.cmd_word = w;
        ticks(2);
        sb.push_back(w[5:0]);
        chk("ack_after_push", 32'(bus.ack_word), 32'(exp_ack));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.cmd_word  = 7'h40;
        bus.out_ready = 1'b0;
        @(negedge clk);
        ticks(3);
        chk("reset_ack", 32'(bus.ack_word), 32'h00);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_head", {26'd0, bus.out_op, bus.out_arg}, 32'd0);

        // Toggle already high at reset release must not produce a command.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("arm_ack", 32'(bus.ack_word), 32'h00);
            chk("arm_valid", 32'(bus.out_valid), 32'd0);
        end

        // Toggle to 0 with a NOP, then DIR right with toggle 1.
        bus.cmd_word = 7'h00;
        ticks(3);
        chk("nop_ack", 32'(bus.ack_word), 32'h00);
        bus.out_ready = 1'b1;
        bus.cmd_word  = 7'h52;
        tick();
        chk("lat_t_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_t_ack", 32'(bus.ack_word), 32'h00);
        tick();
        sb.push_back(6'h12);
        chk("lat_t1_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_t1_ack", 32'(bus.ack_word), 32'h51);
        tick();
        chk("pulse_valid", 32'(bus.out_valid), 32'd0);
        chk("pulse_ack", 32'(bus.ack_word), 32'h50);

        // Fill the queue with the engine stalled; the fifth command pends.
        bus.out_ready = 1'b0;
        send_acked(7'h21, 7'h21);
        send_acked(7'h77, 7'h72);
        send_acked(7'h10, 7'h13);
        send_acked(7'h7F, 7'h74);
        bus.cmd_word = 7'h12;
        ticks(3);
        chk("pend_no_ack", 32'(bus.ack_word), 32'h74);

        // Reverting the toggle while pending flags a protocol error.
        bus.cmd_word = 7'h40;
        ticks(2);
        chk("pend_proto_err", 32'(bus.ack_word), 32'h7C);

        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("pend_after_pop", 32'(bus.ack_word), 32'h7B);
        tick();
        sb.push_back(6'h12);
        chk("pend_pushed", 32'(bus.ack_word), 32'h1C);
        tick();
        chk("revert_as_nop", 32'(bus.ack_word), 32'h4C);

        // NOP with arg[0]=1 clears the sticky error and queues nothing.
        bus.cmd_word = 7'h01;
        ticks(2);
        chk("err_clear", 32'(bus.ack_word), 32'h04);

        // Drain to two entries, then push and pop on the same edge.
        bus.out_ready = 1'b1;
        ticks(2);
        bus.out_ready = 1'b0;
        chk("two_entries", 32'(bus.ack_word), 32'h02);
        bus.cmd_word = 7'h73;
        tick();
        bus.out_ready = 1'b1;
        tick();
        sb.push_back(6'h33);
        chk("simul_count", 32'(bus.ack_word), 32'h72);
        chk("simul_head", {26'd0, bus.out_op, bus.out_arg}, 32'h12);
        ticks(2);
        chk("drained_valid", 32'(bus.out_valid), 32'd0);
        chk("drained_ack", 32'(bus.ack_word), 32'h70);
        bus.out_ready = 1'b0;

        // Reset during PEND with a full queue drops everything.
        send_acked(7'h20, 7'h21);
        send_acked(7'h61, 7'h62);
        send_acked(7'h11, 7'h13);
        send_acked(7'h79, 7'h74);
        bus.cmd_word = 7'h23;
        ticks(3);
        chk("pend2_no_ack", 32'(bus.ack_word), 32'h74);
        reset = 1'b1;
        tick();
        sb.delete();
        chk("rst_pend_ack", 32'(bus.ack_word), 32'h00);
        chk("rst_pend_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_lost_valid", 32'(bus.out_valid), 32'd0);
            chk("held_lost_ack", 32'(bus.ack_word), 32'h00);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
